// File: rtl/uart_rx_deserializer.sv
// UART receive stage: 2-FF synchronizer, oversampling divider, midpoint-sampling FSM
// and a one-entry valid/ready holding register. Define UART_RX_PARITY_EN for 8E1 (default 8N1).
module uart_rx_deserializer #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_error,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int DIV_RAW     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W      = $clog2(OVERSAMPLE);
    localparam int SYNC_STAGES = 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t              state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DIV_W-1:0]    div_reg;
    logic [TICK_W-1:0]   tick_reg;
    logic [2:0]          bit_reg;
    logic [7:0]          shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                parity_err_reg;
`endif
    logic                rx_s;
    logic                tick;

    // Idle-high line, so the synchronizer resets to 1 to avoid a spurious start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];
    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;

            // A completed byte later in this block overrides this clear.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (state_reg != S_IDLE) begin
                div_reg <= tick ? '0 : div_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= S_START;
                        rx_busy   <= 1'b1;
                        div_reg   <= '0;
                        tick_reg  <= '0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (tick_reg == HALF_LAST) begin
                            tick_reg <= '0;
                            bit_reg  <= '0;
                            if (rx_s) begin
                                state_reg <= S_IDLE;
                                rx_busy   <= 1'b0;
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        if (tick_reg == FULL_LAST) begin
                            tick_reg  <= '0;
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= S_PARITY;
`else
                                state_reg <= S_STOP;
`endif
                            end else begin
                                bit_reg <= bit_reg + 1'b1;
                            end
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        if (tick_reg == FULL_LAST) begin
                            tick_reg       <= '0;
                            parity_err_reg <= (^shift_reg) ^ rx_s;
                            state_reg      <= S_STOP;
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end
`endif

                S_STOP: begin
                    if (tick) begin
                        if (tick_reg == FULL_LAST) begin
                            tick_reg <= '0;
                            if (!rx_s) begin
                                // Framing error: park until the line is released.
                                rx_error  <= 1'b1;
                                state_reg <= S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                            end else if (parity_err_reg) begin
                                rx_error  <= 1'b1;
                                state_reg <= S_IDLE;
                                rx_busy   <= 1'b0;
`endif
                            end else begin
                                state_reg <= S_IDLE;
                                rx_busy   <= 1'b0;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift_reg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            tick_reg <= tick_reg + 1'b1;
                        end
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_reg <= S_IDLE;
                        rx_busy   <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: vector table, hand-written corner cases
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_deserializer;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx_deserializer #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_serial(rx_serial),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_error(rx_error),
        .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int err_cnt   = 0;
    int ovr_cnt   = 0;
    logic [7:0] acc_q[$];

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_error)   err_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        clocks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ pflip);
`endif
        send_bit(stop);
        rx_serial = 1'b1;
        $display("frame data=0x%02h stop=%0d pflip=%0d", d, stop, pflip);
    endtask

    task automatic clear_obs();
        err_cnt = 0;
        ovr_cnt = 0;
        acc_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        logic       exp_valid;
        logic       exp_error;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];
    int exp_err;

    initial begin
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h03, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hC4, 1'b1, 1'b1, 1'b0, 1'b1});
`endif

        // Reset values
        rst_n = 1'b0;
        clocks(4);
        @(negedge clk);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_error", 32'(rx_error), 32'd0);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clocks(4);

        // Single byte held until accepted
        clear_obs();
        rx_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b0);
        clocks(2);
        check("single_valid", 32'(rx_valid), 32'd1);
        check("single_data", 32'(rx_data), 32'h42);
        check("single_error", 32'(err_cnt), 32'd0);
        clocks(10);
        check("single_hold", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        clocks(1);
        check("single_drop", 32'(rx_valid), 32'd0);
        check("single_accept_cnt", 32'(acc_q.size()), 32'd1);

        // Back-to-back frames, consumer always ready
        clear_obs();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        clocks(4);
        check("b2b_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            check("b2b_first", 32'(acc_q[0]), 32'hA5);
            check("b2b_second", 32'(acc_q[1]), 32'h3C);
        end
        check("b2b_overrun", 32'(ovr_cnt), 32'd0);

        // Overrun: second byte dropped while first is pending
        clear_obs();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        clocks(4);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_pulses", 32'(ovr_cnt), 32'd1);
        rx_ready = 1'b1;
        clocks(3);
        check("ovr_drain_count", 32'(acc_q.size()), 32'd1);

        // Framing error followed by a break
        clear_obs();
        send_frame(8'h55, 1'b0, 1'b0);
        rx_serial = 1'b0;
        clocks(100);
        rx_serial = 1'b1;
        clocks(6);
        check("break_error_pulses", 32'(err_cnt), 32'd1);
        check("break_no_valid", 32'(acc_q.size()), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        clocks(4);
        check("after_break_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() == 1) check("after_break_data", 32'(acc_q[0]), 32'h0F);

        // Glitch: false start
        clear_obs();
        rx_serial = 1'b0;
        clocks(4);
        rx_serial = 1'b1;
        check("glitch_busy_rise", 32'(rx_busy), 32'd1);
        clocks(8);
        check("glitch_busy_fall", 32'(rx_busy), 32'd0);
        clocks(40);
        check("glitch_no_error", 32'(err_cnt), 32'd0);
        check("glitch_no_valid", 32'(acc_q.size()), 32'd0);
        check("glitch_idle", 32'(rx_busy), 32'd0);

        // Vector table
        foreach (vecs[k]) begin
            clear_obs();
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].pflip);
            clocks(8);
            check($sformatf("vec%0d_valid", k), 32'(acc_q.size()), 32'(vecs[k].exp_valid));
            if (vecs[k].exp_valid && acc_q.size() == 1)
                check($sformatf("vec%0d_data", k), 32'(acc_q[0]), 32'(vecs[k].data));
            check($sformatf("vec%0d_error", k), 32'(err_cnt), 32'(vecs[k].exp_error));
        end

        // Reset during bit 4 clears a pending byte and the partial frame
        clear_obs();
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0);
        clocks(2);
        check("pre_reset_valid", 32'(rx_valid), 32'd1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_serial = 1'b0;
        clocks(8);
        rst_n = 1'b0;
        rx_serial = 1'b1;
        clocks(2);
        @(negedge clk);
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_error", 32'(rx_error), 32'd0);
        check("midrst_overrun", 32'(rx_overrun), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clocks(4);
        clear_obs();
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        clocks(4);
        check("post_reset_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() == 1) check("post_reset_data", 32'(acc_q[0]), 32'h5A);
        check("post_reset_error", 32'(err_cnt), 32'd0);

        // Randomized frames against a frame-level model
        clear_obs();
        exp_q.delete();
        exp_err = 0;
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic stop_ok;
            logic pflip;
            int gap;
            d = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
            pflip = ($urandom_range(0, 5) == 0);
`endif
            gap = stop_ok ? $urandom_range(0, 10) : $urandom_range(6, 12);
            if (stop_ok && !pflip) exp_q.push_back(d);
            else exp_err++;
            send_frame(d, stop_ok, pflip);
            if (gap > 0) clocks(gap);
        end
        clocks(8);
        check("rand_count", 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            check($sformatf("rand_byte%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        check("rand_errors", 32'(err_cnt), 32'(exp_err));
        check("rand_overrun", 32'(ovr_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
